// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver.
// Holds the receiver FSM state encoding and the scan-code prefixes the receiver filters out.
package ps2_pkg;

    typedef enum logic [2:0] {
        StReposo,
        StDatos,
        StParidad,
        StParada,
        StValidar
    } estado_e;

    // Prefix that announces a key release (break sequence F0 xx)
    localparam logic [7:0] CodBreak = 8'hF0;
    // Prefix of extended scan codes (E0 xx)
    localparam logic [7:0] CodExt   = 8'hE0;

endpackage

// File: rtl/filtro_ps2.sv
// Conditioning for the asynchronous ps2_clk pin.
// A 2-FF synchroniser is followed by a stability counter: the filtered level only follows the
// synchronised input after Filtro consecutive samples that differ from the current filtered level.
// A one-cycle pulse marks each accepted 1->0 transition.
// Ports:
//   clk_i            system clock
//   reset_i          asynchronous active-high reset (filter loads idle level 1)
//   senal_i          asynchronous pin
//   flanco_bajada_o  one-cycle pulse, filtered level just went 1->0
module filtro_ps2 #(
    parameter int unsigned Filtro = 8
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic senal_i,
    output logic flanco_bajada_o
);

    localparam int unsigned    CntW   = (Filtro > 1) ? $clog2(Filtro) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(Filtro - 1);

    logic            sync1_q, sync2_q;
    logic            nivel_q, nivel_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            flanco_q, flanco_d;

    always_comb begin
        nivel_d  = nivel_q;
        cnt_d    = '0;
        flanco_d = 1'b0;
        // The counter only runs while the input disagrees with the filtered level; any
        // agreeing sample restarts the count, so short glitches never get through.
        if (sync2_q != nivel_q) begin
            if (cnt_q == CntMax) begin
                nivel_d  = sync2_q;
                flanco_d = nivel_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            nivel_q  <= 1'b1;
            cnt_q    <= '0;
            flanco_q <= 1'b0;
        end else begin
            sync1_q  <= senal_i;
            sync2_q  <= sync1_q;
            nivel_q  <= nivel_d;
            cnt_q    <= cnt_d;
            flanco_q <= flanco_d;
        end
    end

    assign flanco_bajada_o = flanco_q;

endmodule

// File: rtl/receptor_teclado_ps2.sv
// PS/2 keyboard receiver feeding the challenge-mode game FSM.
// Deserialises 11-bit device-clocked frames (start, D0..D7 LSB first, odd parity, stop) and
// delivers one make code per keypress: break sequences (F0 xx) and E0 prefixes are swallowed.
// Ports:
//   clk_i           system clock (25 MHz)
//   reset_i         asynchronous active-high reset
//   ps2_clk_i       keyboard clock pin, idle high
//   ps2_data_i      keyboard data pin, idle high
//   nota_usuario_o  last accepted make code, held until the next accept
//   dato_listo_o    one-cycle pulse, nota_usuario_o just updated
//   error_trama_o   one-cycle pulse, frame rejected (start/parity/stop error or timeout)
module receptor_teclado_ps2
    import ps2_pkg::*;
#(
    parameter int unsigned Filtro  = 8,
    parameter int unsigned Timeout = 2500
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] nota_usuario_o,
    output logic       dato_listo_o,
    output logic       error_trama_o
);

    localparam int unsigned    TmoW   = $clog2(Timeout);
    localparam logic [TmoW-1:0] TmoMax = TmoW'(Timeout - 1);

    logic            flanco;
    logic            data_sync1_q, data_sync2_q;

    estado_e         estado_q, estado_d;
    logic [3:0]      bits_q, bits_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            brk_q, brk_d;
    logic [7:0]      nota_q, nota_d;
    logic            listo_q, listo_d;
    logic            err_q, err_d;

    filtro_ps2 #(
        .Filtro (Filtro)
    ) u_filtro_clk (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .senal_i         (ps2_clk_i),
        .flanco_bajada_o (flanco)
    );

    always_comb begin
        estado_d = estado_q;
        bits_d   = bits_q;
        shift_d  = shift_q;
        par_d    = par_q;
        tmo_d    = tmo_q;
        brk_d    = brk_q;
        nota_d   = nota_q;
        listo_d  = 1'b0;
        err_d    = 1'b0;

        unique case (estado_q)
            StReposo: begin
                tmo_d  = '0;
                bits_d = '0;
                if (flanco) begin
                    if (!data_sync2_q) begin
                        estado_d = StDatos;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            StDatos, StParidad, StParada: begin
                if (flanco) begin
                    tmo_d = '0;
                    unique case (estado_q)
                        StDatos: begin
                            shift_d[bits_q[2:0]] = data_sync2_q;
                            if (bits_q == 4'd7) begin
                                estado_d = StParidad;
                            end else begin
                                bits_d = bits_q + 4'd1;
                            end
                        end
                        StParidad: begin
                            par_d    = data_sync2_q;
                            estado_d = StParada;
                        end
                        default: begin
                            bits_d = '0;
                            // Odd parity: data byte plus parity bit carries an odd number of ones
                            if (data_sync2_q && (^{shift_q, par_q})) begin
                                estado_d = StValidar;
                            end else begin
                                err_d    = 1'b1;
                                estado_d = StReposo;
                            end
                        end
                    endcase
                end else if (tmo_q == TmoMax) begin
                    // Keyboard stopped clocking mid-frame: drop it and resynchronise
                    err_d    = 1'b1;
                    estado_d = StReposo;
                    bits_d   = '0;
                    tmo_d    = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            StValidar: begin
                estado_d = StReposo;
                if (shift_q == CodBreak) begin
                    brk_d = 1'b1;
                end else if (shift_q == CodExt) begin
                    brk_d = brk_q;
                end else if (brk_q) begin
                    // Code following F0 is the released key; the game only wants presses
                    brk_d = 1'b0;
                end else begin
                    nota_d  = shift_q;
                    listo_d = 1'b1;
                end
            end

            default: begin
                estado_d = StReposo;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            data_sync1_q <= 1'b1;
            data_sync2_q <= 1'b1;
            estado_q     <= StReposo;
            bits_q       <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            tmo_q        <= '0;
            brk_q        <= 1'b0;
            nota_q       <= 8'h00;
            listo_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            data_sync1_q <= ps2_data_i;
            data_sync2_q <= data_sync1_q;
            estado_q     <= estado_d;
            bits_q       <= bits_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            tmo_q        <= tmo_d;
            brk_q        <= brk_d;
            nota_q       <= nota_d;
            listo_q      <= listo_d;
            err_q        <= err_d;
        end
    end

    assign nota_usuario_o = nota_q;
    assign dato_listo_o   = listo_q;
    assign error_trama_o  = err_q;

endmodule

// File: tb/tb_receptor_teclado_ps2.sv
// Directed bench for receptor_teclado_ps2: drives PS/2 frames on the pins and checks the
// accepted codes and strobe/error pulse counts against hand-computed expectations.
// The PS/2 bit period is shortened to 10 us (data set 5 us before each falling edge) so the run
// stays short; the receiver only depends on edges and the 100 us timeout, which is unchanged.
module tb_receptor_teclado_ps2;

    localparam int unsigned Filtro  = 8;
    localparam int unsigned Timeout = 2500;
    localparam int          THalf   = 5000;  // half PS/2 bit period (clk period is 40)

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] nota;
    logic       listo;
    logic       err;

    int n_chk   = 0;
    int n_bad   = 0;
    int listo_n = 0;
    int err_n   = 0;
    int both_n  = 0;
    int cyc     = 0;
    int stop_cyc  = 0;
    int listo_cyc = 0;

    always #20 clk = ~clk;

    receptor_teclado_ps2 #(
        .Filtro  (Filtro),
        .Timeout (Timeout)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .ps2_clk_i      (ps2_clk),
        .ps2_data_i     (ps2_data),
        .nota_usuario_o (nota),
        .dato_listo_o   (listo),
        .error_trama_o  (err)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters, sampled on the inactive edge
    always @(negedge clk) begin
        if (listo) begin
            listo_n   <= listo_n + 1;
            listo_cyc <= cyc;
        end
        if (err) err_n <= err_n + 1;
        if (listo && err) both_n <= both_n + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par,
                                             input logic bad_stop);
        logic p;
        p = ~(^b) ^ bad_par;
        return {~bad_stop, p, b, 1'b0};
    endfunction

    task automatic ps2_bits(input logic [10:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = frame[i];
            #THalf;
            ps2_clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            #THalf;
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        ps2_bits(mk_frame(b, bad_par, bad_stop), 11);
        ps2_data = 1'b1;
        #(2 * THalf);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        bit  found;

        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_nota", nota, 8'h00);
        check_val("rst_listo", listo, 1'b0);
        check_val("rst_err", err, 1'b0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // Plain make code
        send_frame(8'h1C, 1'b0, 1'b0);
        check_val("make_cnt", listo_n, 1);
        check_val("make_nota", nota, 8'h1C);
        check_val("make_err", err_n, 0);
        lat = listo_cyc - stop_cyc;
        check_val("make_latency", (lat >= int'(Filtro) + 2 && lat <= int'(Filtro) + 6), 1'b1);

        // Release sequence F0 1C is swallowed
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        check_val("break_cnt", listo_n, 1);
        check_val("break_nota", nota, 8'h1C);

        // Extended prefix dropped, code delivered
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        check_val("ext_cnt", listo_n, 2);
        check_val("ext_nota", nota, 8'h75);
        check_val("ext_err", err_n, 0);

        // Parity error, then recovery
        send_frame(8'h1C, 1'b1, 1'b0);
        check_val("par_err", err_n, 1);
        check_val("par_cnt", listo_n, 2);
        check_val("par_nota", nota, 8'h75);
        send_frame(8'h23, 1'b0, 1'b0);
        check_val("par_next_cnt", listo_n, 3);
        check_val("par_next_nota", nota, 8'h23);

        // Stop bit low
        send_frame(8'h2B, 1'b0, 1'b1);
        check_val("stop_err", err_n, 2);
        check_val("stop_cnt", listo_n, 3);

        // Frame abandoned after 5 bits
        ps2_bits(mk_frame(8'h34, 1'b0, 1'b0), 5);
        ps2_data = 1'b1;
        found = 1'b0;
        for (int i = 0; i < int'(Timeout + Filtro + 3); i++) begin
            @(negedge clk);
            if (err) begin
                found = 1'b1;
                break;
            end
        end
        check_val("tmo_seen", found, 1'b1);
        #150000;
        check_val("tmo_err", err_n, 3);
        check_val("tmo_cnt", listo_n, 3);
        send_frame(8'h23, 1'b0, 1'b0);
        check_val("tmo_next_cnt", listo_n, 4);
        check_val("tmo_next_nota", nota, 8'h23);

        // Short low glitch on ps2_clk while idle
        ps2_clk = 1'b0;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (50) @(negedge clk);
        check_val("glitch_err", err_n, 3);
        check_val("glitch_cnt", listo_n, 4);

        // Asynchronous reset in the middle of the data bits
        ps2_bits(mk_frame(8'h4D, 1'b0, 1'b0), 4);
        #7;
        reset = 1'b1;
        #1;
        check_val("mid_rst_nota", nota, 8'h00);
        check_val("mid_rst_listo", listo, 1'b0);
        check_val("mid_rst_err", err, 1'b0);
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        send_frame(8'h1C, 1'b0, 1'b0);
        check_val("post_rst_cnt", listo_n, 5);
        check_val("post_rst_nota", nota, 8'h1C);
        check_val("post_rst_err", err_n, 3);
        check_val("never_both", both_n, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
